// File: rtl/mips_multicycle_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : mips_multicycle_ctl
//  Purpose  : Moore-style control FSM for the multi-cycle MIPS datapath.
//             Sequences fetch/decode/execute/memory/writeback and drives
//             all datapath enables, mux selects and the 4-bit ALU opcode.
//  Options  : MIPS_CTL_BNE_EN - when defined, opcode 0x05 (bne) is decoded
//             as a branch; otherwise it is treated as an illegal opcode.
//  Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctl #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       ext_zero,
  output logic [1:0] pcsrc,
  output logic [3:0] aluctl,
  output logic       illegal,
  output logic [3:0] state
);

`ifdef MIPS_CTL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  state_t     state_q, state_d;
  state_t     w_illegal_next;
  logic       w_is_mem, w_is_rtype, w_is_branch, w_is_bne, w_is_imm, w_is_jump;
  logic       w_funct_ok;
  logic [3:0] w_rt_aluctl;
  logic [3:0] w_imm_aluctl;
  logic       w_imm_ext_zero;

  assign w_illegal_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
  assign w_is_mem       = (opcode == OP_LW) || (opcode == OP_SW);
  assign w_is_rtype     = (opcode == OP_RTYPE);
  assign w_is_bne       = BNE_EN && (opcode == OP_BNE);
  assign w_is_branch    = (opcode == OP_BEQ) || w_is_bne;
  assign w_is_imm       = (opcode == OP_ADDI) || (opcode == OP_SLTI) ||
                          (opcode == OP_ANDI) || (opcode == OP_ORI)  ||
                          (opcode == OP_LUI);
  assign w_is_jump      = (opcode == OP_J);
  assign state          = state_q;

  // R-type funct to ALU operation; unknown funct flags the instruction illegal
  always_comb begin
    w_funct_ok  = 1'b1;
    w_rt_aluctl = 4'd2;
    case (funct)
      6'h20:   w_rt_aluctl = 4'd2;
      6'h22:   w_rt_aluctl = 4'd6;
      6'h24:   w_rt_aluctl = 4'd0;
      6'h25:   w_rt_aluctl = 4'd1;
      6'h27:   w_rt_aluctl = 4'd12;
      6'h2A:   w_rt_aluctl = 4'd7;
      default: w_funct_ok  = 1'b0;
    endcase
  end

  // Immediate-class ALU operation and extension mode, shared by IMMEX and IMMWB
  always_comb begin
    w_imm_aluctl   = 4'd2;
    w_imm_ext_zero = 1'b0;
    case (opcode)
      OP_SLTI: w_imm_aluctl = 4'd7;
      OP_ANDI: begin w_imm_aluctl = 4'd0; w_imm_ext_zero = 1'b1; end
      OP_ORI:  begin w_imm_aluctl = 4'd1; w_imm_ext_zero = 1'b1; end
      OP_LUI:  begin w_imm_aluctl = 4'd4; w_imm_ext_zero = 1'b1; end
      default: w_imm_aluctl = 4'd2;
    endcase
  end

  // Next-state and Moore output decode; side-effecting strobes are gated by reset
  always_comb begin
    state_d  = state_q;
    pc_en    = 1'b0;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    ext_zero = 1'b0;
    pcsrc    = 2'b00;
    aluctl   = 4'd2;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pc_en   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        if (w_is_mem)         state_d = S_MEMADR;
        else if (w_is_rtype)  state_d = S_RTEX;
        else if (w_is_branch) state_d = S_BRANCH;
        else if (w_is_imm)    state_d = S_IMMEX;
        else if (w_is_jump)   state_d = S_JUMP;
        else begin
          illegal = 1'b1;
          state_d = w_illegal_next;
        end
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        state_d  = S_FETCH;
      end
      S_RTEX: begin
        alusrca = 1'b1;
        aluctl  = w_rt_aluctl;
        if (w_funct_ok) state_d = S_RTWB;
        else begin
          illegal = 1'b1;
          state_d = w_illegal_next;
        end
      end
      S_RTWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluctl  = 4'd6;
        pcsrc   = 2'b01;
        pc_en   = w_is_bne ? ~zero : zero;
        state_d = S_FETCH;
      end
      S_IMMEX: begin
        alusrca  = 1'b1;
        alusrcb  = 2'b10;
        aluctl   = w_imm_aluctl;
        ext_zero = w_imm_ext_zero;
        state_d  = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
        aluctl   = w_imm_aluctl;
        ext_zero = w_imm_ext_zero;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    if (!rst_n) begin
      pc_en    = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  // State register; reset returns to FETCH immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_multicycle_ctl
//  Purpose  : Self-checking bench for mips_multicycle_ctl: directed table of
//             instructions, halt/reset sequences and random instructions
//             compared against an instruction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctl;

  typedef struct packed {
    logic       pc_en, iord, memread, memwrite, irwrite;
    logic       regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic       ext_zero;
    logic [1:0] pcsrc;
    logic [3:0] aluctl;
    logic       illegal;
    logic [3:0] state;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         cpi;
    int         k;
    logic [3:0] k_alu;
    logic       k_pc;
    logic       k_ill;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, rst_h_n;
  logic [5:0] opcode, funct;
  logic       zero;

  logic       pc_en, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       ext_zero, illegal;
  logic [3:0] aluctl, state;

  logic       h_pc_en, h_iord, h_memread, h_memwrite, h_irwrite, h_regdst, h_memtoreg, h_regwrite, h_alusrca;
  logic [1:0] h_alusrcb, h_pcsrc;
  logic       h_ext_zero, h_illegal;
  logic [3:0] h_aluctl, h_state;

  out_t act_m, act_h;
  assign act_m = {pc_en, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                  alusrcb, ext_zero, pcsrc, aluctl, illegal, state};
  assign act_h = {h_pc_en, h_iord, h_memread, h_memwrite, h_irwrite, h_regdst, h_memtoreg, h_regwrite,
                  h_alusrca, h_alusrcb, h_ext_zero, h_pcsrc, h_aluctl, h_illegal, h_state};

  always #5 clk = ~clk;

  mips_multicycle_ctl #(.ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .ext_zero(ext_zero), .pcsrc(pcsrc), .aluctl(aluctl),
    .illegal(illegal), .state(state)
  );

  mips_multicycle_ctl #(.ILLEGAL_HALT(1'b1)) dut_halt (
    .clk(clk), .rst_n(rst_h_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(h_pc_en), .iord(h_iord), .memread(h_memread), .memwrite(h_memwrite), .irwrite(h_irwrite),
    .regdst(h_regdst), .memtoreg(h_memtoreg), .regwrite(h_regwrite), .alusrca(h_alusrca),
    .alusrcb(h_alusrcb), .ext_zero(h_ext_zero), .pcsrc(h_pcsrc), .aluctl(h_aluctl),
    .illegal(h_illegal), .state(h_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // Instruction classes and the state walk each one takes
  localparam int C_LW = 0, C_SW = 1, C_RT = 2, C_RTBAD = 3, C_BR = 4, C_IMM = 5, C_J = 6, C_ILL = 7;
  int seq_tbl [8][5];
  int seq_len [8];

`ifdef MIPS_CTL_BNE_EN
  localparam bit BNE = 1'b1;
`else
  localparam bit BNE = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit rt_ok(input logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
  endfunction

  function automatic logic [3:0] rt_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   return 4'd6;
      6'h24:   return 4'd0;
      6'h25:   return 4'd1;
      6'h27:   return 4'd12;
      6'h2A:   return 4'd7;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [3:0] imm_alu(input logic [5:0] op);
    case (op)
      6'h0A:   return 4'd7;
      6'h0C:   return 4'd0;
      6'h0D:   return 4'd1;
      6'h0F:   return 4'd4;
      default: return 4'd2;
    endcase
  endfunction

  function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h00: return rt_ok(fn) ? C_RT : C_RTBAD;
      6'h04: return C_BR;
      6'h05: return BNE ? C_BR : C_ILL;
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: return C_IMM;
      6'h02: return C_J;
      default: return C_ILL;
    endcase
  endfunction

  // Expected outputs while in a given state for a given instruction
  function automatic out_t exp_vec(input int st, input logic [5:0] op, input logic [5:0] fn,
                                   input logic z, input int c);
    out_t o;
    o = '0;
    o.aluctl = 4'd2;
    o.state  = st[3:0];
    case (st)
      0:  begin o.memread = 1; o.irwrite = 1; o.alusrcb = 2'b01; o.pc_en = 1; end
      1:  begin o.alusrcb = 2'b11; o.illegal = (c == C_ILL); end
      2:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
      3:  begin o.memread = 1; o.iord = 1; end
      4:  begin o.regwrite = 1; o.memtoreg = 1; end
      5:  begin o.memwrite = 1; o.iord = 1; end
      6:  begin o.alusrca = 1; o.aluctl = rt_alu(fn); o.illegal = (c == C_RTBAD); end
      7:  begin o.regdst = 1; o.regwrite = 1; end
      8:  begin o.alusrca = 1; o.aluctl = 4'd6; o.pcsrc = 2'b01; o.pc_en = (op == 6'h04) ? z : ~z; end
      9:  begin o.alusrca = 1; o.alusrcb = 2'b10; o.aluctl = imm_alu(op);
                o.ext_zero = op inside {6'h0C, 6'h0D, 6'h0F}; end
      10: begin o.regwrite = 1; o.aluctl = imm_alu(op); o.ext_zero = op inside {6'h0C, 6'h0D, 6'h0F}; end
      11: begin o.pcsrc = 2'b10; o.pc_en = 1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic out_t reset_vec();
    out_t o;
    o = '0;
    o.alusrcb = 2'b01;
    o.aluctl  = 4'd2;
    return o;
  endfunction

  // Runs one instruction on the main DUT starting in FETCH; returns observed CPI
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int k,
                           output int cyc, output out_t kv);
    int c, n;
    c   = cls(op, fn);
    n   = seq_len[c];
    kv  = '0;
    cyc = -1;
    for (int i = 0; i < 10; i++) begin
      opcode = op; funct = fn; zero = z;
      #1;
      if (i > 0 && act_m.state == 4'd0) begin cyc = i; break; end
      if (i < n) chk("cycle", 32'(act_m), 32'(exp_vec(seq_tbl[c][i], op, fn, z, c)));
      else       chk("overrun_state", 32'(act_m.state), 32'd0);
      if (i == k) kv = act_m;
      @(negedge clk);
    end
    if (cyc < 0) begin
      n_vec++; n_err++;
      $display("FAIL timeout: op %0h never returned to FETCH", op);
    end
  endtask

  vec_t tbl[$];

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z, input int cpi,
                              input int k, input logic [3:0] ka, input logic kp, input logic ki);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.cpi = cpi; v.k = k; v.k_alu = ka; v.k_pc = kp; v.k_ill = ki;
    return v;
  endfunction

  initial begin
    int   cyc;
    out_t kv;
    logic [5:0] ops [12];
    logic [5:0] fns [7];

    seq_tbl[C_LW]    = '{0, 1, 2, 3, 4}; seq_len[C_LW]    = 5;
    seq_tbl[C_SW]    = '{0, 1, 2, 5, 0}; seq_len[C_SW]    = 4;
    seq_tbl[C_RT]    = '{0, 1, 6, 7, 0}; seq_len[C_RT]    = 4;
    seq_tbl[C_RTBAD] = '{0, 1, 6, 0, 0}; seq_len[C_RTBAD] = 3;
    seq_tbl[C_BR]    = '{0, 1, 8, 0, 0}; seq_len[C_BR]    = 3;
    seq_tbl[C_IMM]   = '{0, 1, 9, 10, 0}; seq_len[C_IMM]  = 4;
    seq_tbl[C_J]     = '{0, 1, 11, 0, 0}; seq_len[C_J]    = 3;
    seq_tbl[C_ILL]   = '{0, 1, 0, 0, 0}; seq_len[C_ILL]   = 2;

    //            op     fn     z  cpi k  alu    pc ill
    tbl.push_back(mk(6'h23, 6'h00, 0, 5, 2, 4'd2,  0, 0));
    tbl.push_back(mk(6'h2B, 6'h00, 0, 4, 2, 4'd2,  0, 0));
    tbl.push_back(mk(6'h00, 6'h27, 0, 4, 2, 4'd12, 0, 0));
    tbl.push_back(mk(6'h00, 6'h20, 0, 4, 2, 4'd2,  0, 0));
    tbl.push_back(mk(6'h00, 6'h22, 1, 4, 2, 4'd6,  0, 0));
    tbl.push_back(mk(6'h00, 6'h24, 0, 4, 2, 4'd0,  0, 0));
    tbl.push_back(mk(6'h00, 6'h25, 0, 4, 2, 4'd1,  0, 0));
    tbl.push_back(mk(6'h00, 6'h2A, 0, 4, 2, 4'd7,  0, 0));
    tbl.push_back(mk(6'h00, 6'h3F, 0, 3, 2, 4'd2,  0, 1));
    tbl.push_back(mk(6'h04, 6'h00, 1, 3, 2, 4'd6,  1, 0));
    tbl.push_back(mk(6'h04, 6'h00, 0, 3, 2, 4'd6,  0, 0));
    tbl.push_back(mk(6'h0F, 6'h00, 0, 4, 2, 4'd4,  0, 0));
    tbl.push_back(mk(6'h08, 6'h00, 0, 4, 2, 4'd2,  0, 0));
    tbl.push_back(mk(6'h0A, 6'h00, 0, 4, 2, 4'd7,  0, 0));
    tbl.push_back(mk(6'h0C, 6'h00, 0, 4, 2, 4'd0,  0, 0));
    tbl.push_back(mk(6'h0D, 6'h00, 0, 4, 2, 4'd1,  0, 0));
    tbl.push_back(mk(6'h02, 6'h00, 0, 3, 2, 4'd2,  1, 0));
    tbl.push_back(mk(6'h3F, 6'h00, 0, 2, 1, 4'd2,  0, 1));
`ifdef MIPS_CTL_BNE_EN
    tbl.push_back(mk(6'h05, 6'h00, 0, 3, 2, 4'd6,  1, 0));
    tbl.push_back(mk(6'h05, 6'h00, 1, 3, 2, 4'd6,  0, 0));
`else
    tbl.push_back(mk(6'h05, 6'h00, 0, 2, 1, 4'd2,  0, 1));
    tbl.push_back(mk(6'h05, 6'h00, 1, 2, 1, 4'd2,  0, 1));
`endif

    // Reset: both DUTs held in reset
    rst_n = 1'b0; rst_h_n = 1'b0;
    opcode = 6'h3F; funct = 6'h00; zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_vec", 32'(act_m), 32'(reset_vec()));

    // HALT variant: illegal opcode pulses once, then parks in HALT until reset
    @(negedge clk);
    rst_h_n = 1'b1;
    #1;
    chk("halt_fetch", 32'(act_h), 32'(exp_vec(0, 6'h3F, 6'h00, 0, C_ILL)));
    @(negedge clk); #1;
    chk("halt_decode_illegal", 32'(act_h), 32'(exp_vec(1, 6'h3F, 6'h00, 0, C_ILL)));
    for (int i = 0; i < 12; i++) begin
      out_t hv;
      hv = '0; hv.aluctl = 4'd2; hv.state = 4'd12;
      @(negedge clk); #1;
      chk("halt_hold", 32'(act_h), 32'(hv));
    end
    #2;
    rst_h_n = 1'b0;
    #1;
    chk("halt_async_reset", 32'(act_h), 32'(reset_vec()));
    chk("main_still_reset", 32'(act_m), 32'(reset_vec()));

    // Release main DUT at a falling edge so it starts a clean FETCH
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].k, cyc, kv);
      chk($sformatf("cpi[%0d]", i), 32'(cyc), 32'(tbl[i].cpi));
      chk($sformatf("key_aluctl[%0d]", i), 32'(kv.aluctl), 32'(tbl[i].k_alu));
      chk($sformatf("key_pc_en[%0d]", i), 32'(kv.pc_en), 32'(tbl[i].k_pc));
      chk($sformatf("key_illegal[%0d]", i), 32'(kv.illegal), 32'(tbl[i].k_ill));
    end

    // Reset asserted mid-lw: state returns to FETCH at once, instruction abandoned
    opcode = 6'h23; funct = 6'h00;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("midinstr_memadr", 32'(act_m.state), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midinstr_async_reset", 32'(act_m), 32'(reset_vec()));
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(6'h2B, 6'h00, 1'b0, 0, cyc, kv);
    chk("restart_sw_cpi", 32'(cyc), 32'd4);

    // Random instruction mix against the model
    ops = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00};
    for (int r = 0; r < 300; r++) begin
      logic [5:0] op, fn;
      logic       z;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
      z  = 1'($urandom);
      run_instr(op, fn, z, 0, cyc, kv);
      chk("rand_cpi", 32'(cyc), 32'(seq_len[cls(op, fn)]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_ctl.md
Name: mips_multicycle_ctl

Overview:
- Moore-style control FSM for the multi-cycle MIPS datapath.
- Produces the 4-bit ALU operation code consumed by the team's ALU, plus all datapath enables and mux selects.
- Steps each instruction through fetch/decode/execute/memory/writeback states.
- Uses the ALU's zero flag to resolve branches.

Parameters:
- ILLEGAL_HALT, 0: 0 = illegal instruction pulses illegal and returns to FETCH; 1 = enter HALT until reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], stable from DECODE until next FETCH completes
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- pc_en  out  1  PC write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regdst  out  1  register write destination: 0 = rt, 1 = rd
- memtoreg  out  1  register write data: 0 = ALUOut, 1 = MDR
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A: 0 = PC, 1 = reg A
- alusrcb  out  2  ALU B: 00 = reg B, 01 = const 4, 10 = extended imm, 11 = sign-ext imm<<2
- ext_zero  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- aluctl  out  4  ALU operation: 0 AND, 1 OR, 2 ADD, 4 B<<16, 6 SUB, 7 SLT, 12 NOR
- illegal  out  1  one-cycle pulse on an undecodable instruction
- state  out  4  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11, HALT=12.
- Reset:
  - Async rst_n low: state to FETCH immediately.
  - While rst_n is low, pc_en, memread, memwrite, irwrite, regwrite and illegal are forced 0.
  - All other outputs show the FETCH decode.
- Unlisted outputs are 0 in every state; aluctl defaults to 2.
- Per-state outputs:
  - FETCH: memread=1, irwrite=1, alusrcb=01, aluctl=2, pc_en=1. Next state: DECODE.
  - DECODE: alusrcb=11, aluctl=2 (branch target to ALUOut). Next state by opcode:
    - 0x23 or 0x2B → MEMADR
    - 0x00 → RTEX
    - 0x04 or 0x05 → BRANCH
    - 0x08, 0x0A, 0x0C, 0x0D, 0x0F → IMMEX
    - 0x02 → JUMP
    - anything else → illegal=1, then HALT if ILLEGAL_HALT else FETCH
  - MEMADR: alusrca=1, alusrcb=10, aluctl=2. Next: MEMRD if lw, else MEMWR.
  - MEMRD: memread=1, iord=1. Next: MEMWB.
  - MEMWB: regwrite=1, memtoreg=1. Next: FETCH.
  - MEMWR: memwrite=1, iord=1. Next: FETCH.
  - RTEX: alusrca=1, alusrcb=00, aluctl decoded from funct:
    - 0x20→2, 0x22→6, 0x24→0, 0x25→1, 0x27→12, 0x2A→7
    - other funct: illegal=1 in RTEX, next state as for illegal opcode
    - valid funct: next RTWB
  - RTWB: regdst=1, regwrite=1. Next: FETCH.
  - BRANCH: alusrca=1, aluctl=6, pcsrc=01. pc_en = zero for beq, ~zero for bne. Next: FETCH.
  - IMMEX: alusrca=1, alusrcb=10. aluctl and ext_zero by opcode:
    - addi → aluctl 2
    - slti → aluctl 7
    - andi → aluctl 0, ext_zero=1
    - ori → aluctl 1, ext_zero=1
    - lui → aluctl 4, ext_zero=1
    - Next: IMMWB
  - IMMWB: regwrite=1, regdst=0, memtoreg=0. ext_zero and aluctl are held from IMMEX. Next: FETCH.
  - JUMP: pcsrc=10, pc_en=1. Next: FETCH.
  - HALT: all enables 0; exit only via reset.
- CPI by class:
  - lw 5; sw 4; R-type 4; immediate 4; branch 3; jump 3
  - illegal instruction: 2 cycles before the next FETCH
- Outputs are combinational from state, opcode and funct; no extra latency.
- opcode and funct are don't-care in FETCH, because IR loads at the end of FETCH.
- Reset deasserting mid-instruction: the aborted instruction is not resumed; execution restarts at FETCH.

Optional Feature:
- Macro: MIPS_CTL_BNE_EN.
- Defined: opcode 0x05 (bne) decodes to BRANCH with pc_en=~zero.
- Undefined: 0x05 is illegal, handled exactly as any undecodable opcode.
- beq is unaffected either way.

Test Plan:
- Reset, then release with opcode=0x23 (lw): state sequence 0,1,2,3,4,0. memread=1 in state 3, regwrite=memtoreg=1 in state 4.
- R-type with funct=0x27: aluctl=12 in RTEX, regdst=regwrite=1 in RTWB. Repeat for funct 0x20/0x22/0x24/0x25/0x2A → 2/6/0/1/7.
- beq with zero=1: pc_en=1 and pcsrc=01 in BRANCH. With zero=0: pc_en=0. Next state FETCH in both cases.
- lui (0x0F): aluctl=4 and ext_zero=1 in IMMEX, regwrite=1 in IMMWB.
- opcode 0x3F with ILLEGAL_HALT=1: illegal pulses one cycle in DECODE, then state=12 and stays there 10+ cycles with all enables 0. Asserting rst_n=0 returns state to 0 asynchronously.
- bne (0x05) with zero=0: pc_en=1 when MIPS_CTL_BNE_EN is defined; illegal=1 and return to FETCH when it is not.
